alu_matrix_seq: RTL and testbench

// Parametrised, clocked successor to the combinational matrix ALU of the arithmetic coprocessor.
// - Supports NxN signed matrices with W-bit elements.
// - Uses a start/busy/done handshake and latches operands at start.
// - Adds a sequential matrix multiply: one output element per cycle, N MACs in parallel.
// - Sits between the coprocessor control FSM and the matrix register file.

---
 rtl/alu_matrix_seq.sv | 155 +++++++++++++++
 tb/tb_alu_matrix_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_matrix_seq.sv
// Clocked NxN signed matrix ALU with a start/busy/done handshake.
// Element-wise ops finish in one EXEC cycle; multiply produces one element per cycle.
module alu_matrix_seq #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [N*N*W-1:0]   A_flat,
    input  logic [N*N*W-1:0]   B_flat,
    input  logic [W-1:0]       f,
    output logic [N*N*W-1:0]   C_flat,
    output logic               overflow_flag,
    output logic               err,
    output logic               busy,
    output logic               done
);
    localparam int MB   = N * N * W;
    localparam int ACCW = 2 * W + $clog2(N);
    localparam int IDXW = $clog2(N * N);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NEG = 3'b100;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_SCL = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    state_t state, state_nxt;

    logic [MB-1:0]           a_lat, b_lat, exec_c;
    logic signed [W-1:0]     f_lat, ea, eb, eat;
    logic [2:0]              op_lat;
    logic [IDXW-1:0]         idx;
    logic                    accept, last_idx, exec_ovf, exec_err;
    logic signed [ACCW-1:0]  ewide, mul_acc;
    int                      r, c;

    function automatic logic signed [ACCW-1:0] sx(input logic signed [W-1:0] v);
        return {{(ACCW-W){v[W-1]}}, v};
    endfunction

    function automatic logic out_of_range(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] vmax, vmin;
        vmax = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
        vmin = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};
        return (v > vmax) || (v < vmin);
    endfunction

    // All element-wise results in parallel, at full precision before wrapping.
    always_comb begin
        exec_c   = '0;
        exec_ovf = 1'b0;
        ea       = '0;
        eb       = '0;
        eat      = '0;
        ewide    = '0;
        exec_err = (op_lat == 3'b000) || (op_lat == 3'b111);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ea  = a_lat[(i*N+j)*W +: W];
                eb  = b_lat[(i*N+j)*W +: W];
                eat = a_lat[(j*N+i)*W +: W];
                case (op_lat)
                    OP_ADD:  ewide = sx(ea) + sx(eb);
                    OP_SUB:  ewide = sx(ea) - sx(eb);
                    OP_NEG:  ewide = -sx(ea);
                    OP_TRN:  ewide = sx(eat);
                    OP_SCL:  ewide = sx(ea) * sx(f_lat);
                    default: ewide = '0;
                endcase
                exec_c[(i*N+j)*W +: W] = ewide[W-1:0];
                exec_ovf = exec_ovf | out_of_range(ewide);
            end
        end
    end

    // One dot product per cycle: row r of A against column c of B.
    always_comb begin
        mul_acc = '0;
        r = int'(idx) / N;
        c = int'(idx) % N;
        for (int k = 0; k < N; k++) begin
            mul_acc = mul_acc + sx(a_lat[(r*N+k)*W +: W]) * sx(b_lat[(k*N+c)*W +: W]);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_idx  = (idx == IDXW'(N*N-1));
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (opcode == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC:    state_nxt = IDLE;
            MUL:     if (last_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat  <= A_flat;
            b_lat  <= B_flat;
            f_lat  <= f;
            op_lat <= opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C_flat        <= '0;
            overflow_flag <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            idx           <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                C_flat        <= '0;
                overflow_flag <= 1'b0;
                err           <= 1'b0;
                busy          <= 1'b1;
                idx           <= '0;
            end else if (state == EXEC) begin
                C_flat        <= exec_c;
                overflow_flag <= exec_ovf;
                err           <= exec_err;
                done          <= 1'b1;
                busy          <= 1'b0;
            end else if (state == MUL) begin
                C_flat[idx*W +: W] <= mul_acc[W-1:0];
                overflow_flag      <= overflow_flag | out_of_range(mul_acc);
                idx                <= idx + 1'b1;
                if (last_idx) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_matrix_seq.sv
// Directed bench for alu_matrix_seq at N=5, W=8 with hand-computed expectations.
module tb_alu_matrix_seq;
    localparam int MB = 200;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2:0]    opcode;
    logic [MB-1:0] a_flat, b_flat, c_flat, pat, idm, exp_c;
    logic [7:0]    f;
    logic          overflow_flag, err, busy, done;
    int            n_chk = 0;
    int            n_bad = 0;
    int            cyc, dcyc, ndone;

    alu_matrix_seq #(.N(5), .W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .A_flat(a_flat), .B_flat(b_flat), .f(f), .C_flat(c_flat),
        .overflow_flag(overflow_flag), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [MB-1:0] fill(input logic [7:0] v);
        return {25{v}};
    endfunction

    task automatic run_op(input logic [2:0] op, input int exp_lat, input string tag);
        @(negedge clk);
        opcode = op;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, MB'(busy), MB'(1));
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, MB'(cyc), MB'(exp_lat));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 3'b000;
        a_flat = '0; b_flat = '0; f = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                pat[(i*5+j)*8 +: 8] = 8'(i*5 + j);
                idm[(i*5+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
            end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_c", c_flat, '0);
        chk("rst_flags", MB'({overflow_flag, err, busy, done}), '0);

        a_flat = fill(8'd100); b_flat = fill(8'd50);
        run_op(3'b001, 1, "add");
        chk("add_c", c_flat, fill(8'h96));
        chk("add_ovf_err", MB'({overflow_flag, err}), MB'(2'b10));
        @(posedge clk); #1;
        chk("add_done_pulse", MB'({done, busy}), '0);

        a_flat = fill(8'h9C); b_flat = fill(8'd100);
        run_op(3'b010, 1, "sub");
        chk("sub_c", c_flat, fill(8'h38));
        chk("sub_ovf", MB'(overflow_flag), MB'(1));

        a_flat = idm; b_flat = pat;
        run_op(3'b011, 25, "mul_id");
        chk("mul_id_c", c_flat, pat);
        chk("mul_id_ovf", MB'(overflow_flag), '0);

        a_flat = fill(8'd10); b_flat = fill(8'd10);
        run_op(3'b011, 25, "mul_10");
        chk("mul_10_c", c_flat, fill(8'hF4));
        chk("mul_10_ovf", MB'(overflow_flag), MB'(1));

        a_flat = fill(8'd3); a_flat[7:0] = 8'h80;
        exp_c = fill(8'hFD); exp_c[7:0] = 8'h80;
        run_op(3'b100, 1, "neg");
        chk("neg_c", c_flat, exp_c);
        chk("neg_ovf", MB'(overflow_flag), MB'(1));

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                a_flat[(i*5+j)*8 +: 8] = 8'(i*16 + j);
                exp_c[(i*5+j)*8 +: 8]  = 8'(j*16 + i);
            end
        run_op(3'b101, 1, "trn");
        chk("trn_c", c_flat, exp_c);
        chk("trn_ovf", MB'(overflow_flag), '0);

        a_flat = fill(8'd64); f = 8'hFE;
        run_op(3'b110, 1, "scl_m2");
        chk("scl_m2_c", c_flat, fill(8'h80));
        chk("scl_m2_ovf", MB'(overflow_flag), '0);
        f = 8'hFD;
        run_op(3'b110, 1, "scl_m3");
        chk("scl_m3_c", c_flat, fill(8'h40));
        chk("scl_m3_ovf", MB'(overflow_flag), MB'(1));

        run_op(3'b111, 1, "op111");
        chk("op111_c", c_flat, '0);
        chk("op111_ovf_err", MB'({overflow_flag, err}), MB'(2'b01));
        a_flat = fill(8'd7);
        run_op(3'b000, 1, "op000");
        chk("op000_c", c_flat, '0);
        chk("op000_err", MB'(err), MB'(1));

        // Start during a multiply is ignored; start on the done cycle is taken.
        @(negedge clk);
        a_flat = idm; b_flat = pat; opcode = 3'b011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0; dcyc = 0;
        while (cyc < 40 && dcyc == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 4) begin start = 1'b1; opcode = 3'b001; a_flat = fill(8'd100); end
            if (cyc == 5) start = 1'b0;
            if (done) dcyc = cyc;
        end
        chk("hs_lat", MB'(dcyc), MB'(25));
        chk("hs_c", c_flat, pat);
        chk("hs_ovf", MB'(overflow_flag), '0);
        start = 1'b1; opcode = 3'b100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hs_again_acc", MB'({done, busy}), MB'(2'b01));
        @(posedge clk); #1;
        chk("hs_again_done", MB'(done), MB'(1));
        chk("hs_again_c", c_flat, fill(8'h9C));
        chk("hs_again_ovf", MB'(overflow_flag), '0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        a_flat = idm; b_flat = pat; opcode = 3'b011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        chk("rst_mid_c", c_flat, '0);
        chk("rst_mid_flags", MB'({overflow_flag, err, busy, done}), '0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rst_mid_nodone", MB'(ndone), '0);

        a_flat = fill(8'd1); b_flat = fill(8'd1);
        run_op(3'b001, 1, "post_rst_add");
        chk("post_rst_c", c_flat, fill(8'd2));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
